uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Synthesizable UART receiver peripheral for the CPU's serial port. It is the receive-side counterpart of the existing UART transmit path.
- Takes the asynchronous uart_rx pin, oversamples it 16x and recovers 8-bit frames with optional parity.
- Presents each byte to the bus/peripheral logic through a one-entry valid/ready holding register, with sticky error status.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line bit rate.
- PARITY, 0: parity mode; 0 none, 1 odd, 2 even.
- Derived localparam DIV = CLK_FREQ/(BAUD_RATE*16), floor, minimum 1. This is the number of clocks per oversample tick.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- uart_rx  in  1  serial input; idles high; asynchronous to clk.
- rx_data  out  8  received byte, LSB first on the line.
- rx_valid  out  1  rx_data holds an unread byte.
- rx_ready  in  1  consumer accepts rx_data on the cycle where rx_valid && rx_ready.
- frame_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky: parity mismatch; never set when PARITY=0.
- overrun  out  1  sticky: a byte completed while the holding register was full and not being consumed.
- err_clr  in  1  clears all three sticky flags in the same cycle.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, all error flags=0.
  - FSM=IDLE, counters=0.
  - Synchronizer flops reset to 1.
- Input conditioning: 2-flop synchronizer, then a registered copy for falling-edge detection.
- Tick generator:
  - Counter runs 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - Forced to 0 while in IDLE.
  - Starts counting on the cycle the synchronized falling edge is seen.
- Sample counter: 0..15 per bit, advances on each tick. The bit decision is a 2-of-3 majority of the samples at ticks 7, 8 and 9, taken at tick 9.
- FSM states and transitions:
  - IDLE: on synchronized falling edge -> START.
  - START: at decision, majority 1 -> IDLE (glitch rejected, nothing reported). Majority 0 -> DATA at sample count 15 wrap.
  - DATA: shifts 8 bits LSB first, then goes to PARITY if PARITY!=0, else to STOP.
  - PARITY: compares the received bit against the XOR of the data, inverted for odd. A mismatch sets parity_err and marks the byte bad.
  - STOP: acts at tick 9 of the stop bit.
    - Majority 1 with a good byte -> deliver, then IDLE.
    - Majority 1 with a parity-bad byte -> discard, then IDLE.
    - Majority 0 -> set frame_err, discard the byte, go to BREAK.
  - BREAK: waits for synchronized uart_rx=1, then -> IDLE. A held-low line never produces repeated frames.
- Delivery:
  - rx_data is loaded and rx_valid set on the cycle after the stop decision.
  - From the stop-bit midpoint, rx_valid rises 1 clock later.
  - Leaving STOP at mid-stop lets the next start edge be caught half a bit early.
- Handshake:
  - rx_valid clears on the cycle after rx_valid && rx_ready.
  - rx_data stays stable while rx_valid=1.
  - Delivery in the same cycle as consumption loads the new byte, keeps rx_valid=1 and does not flag overrun.
  - Delivery while rx_valid=1 && !rx_ready: the new byte is dropped, the old byte is kept, overrun is set.
- Errors and clear:
  - Set and err_clr in the same cycle: the set wins.
  - Error flags never clear rx_valid.
- Reset mid-frame: everything returns to reset values immediately. A partially received frame is lost.

Decomposition:
- Shared uart package holds:
  - Parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK).
  - The oversample constant 16 and the DIV computation function, shared with the transmitter.
- One sub-module: uart_baud_tick, the resettable tick divider. The transmitter reuses it.

Test Plan (CLK_FREQ=100000000, BAUD_RATE=6250000, so DIV=1 and a bit is 16 clocks):
- Send 0x55 with PARITY=0, rx_ready=0 -> rx_valid=1 one clock after the stop midpoint, rx_data=0x55, no flags. Pulse rx_ready -> rx_valid=0 on the next cycle.
- Send 0xA3 with PARITY=2 (even) and a correct parity bit -> rx_data=0xA3 delivered. Repeat with the parity bit flipped -> no delivery, parity_err=1. Pulse err_clr -> parity_err=0.
- Drive uart_rx low for 4 clocks, then high -> FSM returns to IDLE, no delivery, no flags.
- Send 0x0F with the stop bit low, holding uart_rx low for 40 more clocks -> frame_err=1, no delivery, receiver stays in BREAK. Release the line, then send 0x3C -> 0x3C delivered.
- Send 0x11 then 0x22 back to back with rx_ready=0 -> rx_data=0x11, overrun=1. Repeat with rx_ready pulsed exactly on 0x22's delivery cycle -> rx_data=0x22, overrun stays 0.
- Deassert rst_n mid-DATA of 0x7E, release it, then send 0x81 -> all outputs 0 during reset, 0x81 delivered cleanly afterwards.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: parity modes, receiver states, oversampling and
// the clock divider calculation used by both the receive and transmit paths.
package uart_receiver_pkg;

    localparam int PAR_NONE   = 0;
    localparam int PAR_ODD    = 1;
    localparam int PAR_EVEN   = 2;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Clocks per oversample tick, never below one.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        int d;
        d = clk_freq / (baud_rate * OVERSAMPLE);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_receiver_baud_tick.sv
// Resettable oversample tick divider: counts 0..DIV-1 and pulses tick at DIV-1.
// While clear is high the count is held at zero and no tick is produced.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampling UART receiver with optional parity, a one-entry
// valid/ready holding register and sticky frame/parity/overrun flags.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    input  logic       err_clr
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);

    rx_state_t  state, next_state;
    logic       sync1, sync2, sync3;
    logic       fall, tick, tick_clear;
    logic [3:0] sample_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;
    logic       smp7, smp8, byte_bad;
    logic       decide, wrap, bit_val, exp_par;
    logic       deliver, set_frame, set_parity, set_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign fall       = sync3 && !sync2;
    assign tick_clear = (state == ST_IDLE);

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .tick  (tick)
    );

    assign decide  = tick && (sample_cnt == 4'd9);
    assign wrap    = tick && (sample_cnt == 4'd15);
    assign bit_val = (smp7 & smp8) | (smp7 & sync2) | (smp8 & sync2);
    assign exp_par = (^shift_reg) ^ (PARITY == PAR_ODD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        deliver    = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
        case (state)
            ST_IDLE:   if (fall) next_state = ST_START;
            ST_START: begin
                if (decide && bit_val) next_state = ST_IDLE;
                else if (wrap)         next_state = ST_DATA;
            end
            ST_DATA: begin
                if (wrap && bit_idx == 3'd7)
                    next_state = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (decide && (bit_val != exp_par) && (PARITY != PAR_NONE)) set_parity = 1'b1;
                if (wrap) next_state = ST_STOP;
            end
            // Leaving at mid-stop lets the next start edge be caught early.
            ST_STOP: begin
                if (decide) begin
                    if (bit_val) begin
                        deliver    = !byte_bad;
                        next_state = ST_IDLE;
                    end else begin
                        set_frame  = 1'b1;
                        next_state = ST_BREAK;
                    end
                end
            end
            ST_BREAK:  if (sync2) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            smp7       <= 1'b0;
            smp8       <= 1'b0;
            byte_bad   <= 1'b0;
        end else if (state == ST_IDLE) begin
            sample_cnt <= '0;
            bit_idx    <= '0;
            byte_bad   <= 1'b0;
        end else begin
            if (tick)                         sample_cnt <= sample_cnt + 4'd1;
            if (tick && sample_cnt == 4'd7)   smp7 <= sync2;
            if (tick && sample_cnt == 4'd8)   smp8 <= sync2;
            if (state == ST_DATA && decide)   shift_reg <= {bit_val, shift_reg[7:1]};
            if (state == ST_DATA && wrap)     bit_idx <= bit_idx + 3'd1;
            if (set_parity)                   byte_bad <= 1'b1;
        end
    end

    assign set_overrun = deliver && rx_valid && !rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            frame_err  <= set_frame   ? 1'b1 : (err_clr ? 1'b0 : frame_err);
            parity_err <= set_parity  ? 1'b1 : (err_clr ? 1'b0 : parity_err);
            overrun    <= set_overrun ? 1'b1 : (err_clr ? 1'b0 : overrun);
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: three instances (no, odd, even parity) at one
// 16-clock bit time, driven by a vector table, corner sequences and random frames.
module tb_uart_receiver;

    localparam int BIT_CLKS = 16;

    typedef struct {
        int   ch;
        logic [7:0] data;
        bit   flip;
        bit   stop;
        bit   exp_deliver;
        bit   exp_perr;
        bit   exp_ferr;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       rx_ready;
    logic       err_clr;
    logic       line       [3];
    logic [7:0] rx_data    [3];
    logic       rx_valid   [3];
    logic       frame_err  [3];
    logic       parity_err [3];
    logic       overrun    [3];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int frame_start = 0;
    int rise_cnt [3] = '{0, 0, 0};
    int rise_cyc [3] = '{0, 0, 0};
    bit vprev    [3] = '{0, 0, 0};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_receiver #(
            .CLK_FREQ  (100000000),
            .BAUD_RATE (6250000),
            .PARITY    (g)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .uart_rx    (line[g]),
            .rx_data    (rx_data[g]),
            .rx_valid   (rx_valid[g]),
            .rx_ready   (rx_ready),
            .frame_err  (frame_err[g]),
            .parity_err (parity_err[g]),
            .overrun    (overrun[g]),
            .err_clr    (err_clr)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every rising edge of rx_valid as one delivery.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rx_valid[g] === 1'b1 && !vprev[g]) begin
                rise_cnt[g] = rise_cnt[g] + 1;
                rise_cyc[g] = cyc;
            end
            vprev[g] = (rx_valid[g] === 1'b1);
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic driveBit(input int ch, input logic v, input int n);
        line[ch] = v;
        waitClks(n);
    endtask

    // Parity bit the line should carry: even makes the total ones count even.
    function automatic logic parityBit(input int mode, input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return (mode == 2) ? logic'(ones % 2) : logic'(1 - (ones % 2));
    endfunction

    function automatic vec_t expectFrame(input int ch, input logic [7:0] b, input bit flip, input bit stop);
        vec_t v;
        v.ch          = ch;
        v.data        = b;
        v.flip        = flip;
        v.stop        = stop;
        v.exp_perr    = (ch != 0) && flip;
        v.exp_ferr    = !stop;
        v.exp_deliver = stop && !v.exp_perr;
        return v;
    endfunction

    task automatic sendFrame(input int ch, input logic [7:0] b, input bit flip, input bit stop);
        frame_start = cyc;
        driveBit(ch, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) driveBit(ch, b[i], BIT_CLKS);
        if (ch != 0) driveBit(ch, parityBit(ch, b) ^ flip, BIT_CLKS);
        driveBit(ch, stop, BIT_CLKS);
        line[ch] = 1'b1;
    endtask

    task automatic pulseReady();
        rx_ready = 1'b1;
        waitClks(1);
        rx_ready = 1'b0;
    endtask

    task automatic pulseClr();
        err_clr = 1'b1;
        waitClks(1);
        err_clr = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int r0, lat, stop_off;
        r0 = rise_cnt[v.ch];
        sendFrame(v.ch, v.data, v.flip, v.stop);
        if (!v.stop) begin
            driveBit(v.ch, 1'b0, 40);
            checkOutput({tag, " break_no_frame"}, rise_cnt[v.ch] - r0, 0);
            line[v.ch] = 1'b1;
            waitClks(40);
        end else begin
            waitClks(4);
        end
        checkOutput({tag, " deliveries"}, rise_cnt[v.ch] - r0, int'(v.exp_deliver));
        checkOutput({tag, " rx_valid"}, rx_valid[v.ch], v.exp_deliver);
        if (v.exp_deliver) begin
            checkOutput({tag, " rx_data"}, rx_data[v.ch], v.data);
            lat      = rise_cyc[v.ch] - frame_start;
            stop_off = BIT_CLKS * ((v.ch != 0) ? 10 : 9);
            checkOutput({tag, " valid_in_stop_half"},
                        int'(lat >= stop_off + 8 && lat <= stop_off + 15), 1);
        end
        checkOutput({tag, " parity_err"}, parity_err[v.ch], v.exp_perr);
        checkOutput({tag, " frame_err"}, frame_err[v.ch], v.exp_ferr);
        checkOutput({tag, " overrun"}, overrun[v.ch], 0);
        if (v.exp_deliver) begin
            pulseReady();
            checkOutput({tag, " valid_after_ready"}, rx_valid[v.ch], 0);
        end
        if (v.exp_perr || v.exp_ferr) begin
            pulseClr();
            checkOutput({tag, " flags_after_clr"}, {frame_err[v.ch], parity_err[v.ch]}, 0);
        end
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   r0, lat1, target;

        rst_n    = 1'b0;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        for (int g = 0; g < 3; g++) line[g] = 1'b1;

        vecs.push_back('{0, 8'h55, 0, 1, 1, 0, 0});
        vecs.push_back('{2, 8'hA3, 0, 1, 1, 0, 0});
        vecs.push_back('{2, 8'hA3, 1, 1, 0, 1, 0});
        vecs.push_back('{0, 8'h0F, 0, 0, 0, 0, 1});
        vecs.push_back('{0, 8'h3C, 0, 1, 1, 0, 0});
        vecs.push_back('{1, 8'hA3, 0, 1, 1, 0, 0});
        vecs.push_back('{1, 8'h00, 1, 1, 0, 1, 0});
        vecs.push_back('{2, 8'hFF, 0, 0, 0, 0, 1});

        waitClks(3);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("reset ch%0d outputs", g),
                        {rx_data[g], rx_valid[g], frame_err[g], parity_err[g], overrun[g]}, 0);
        end
        rst_n = 1'b1;
        waitClks(10);

        foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Four-clock low glitch must be rejected as a false start.
        r0 = rise_cnt[0];
        driveBit(0, 1'b0, 4);
        driveBit(0, 1'b1, 40);
        checkOutput("glitch deliveries", rise_cnt[0] - r0, 0);
        checkOutput("glitch flags", {frame_err[0], parity_err[0], overrun[0]}, 0);

        // Back-to-back frames with the consumer stalled.
        r0 = rise_cnt[0];
        sendFrame(0, 8'h11, 0, 1);
        sendFrame(0, 8'h22, 0, 1);
        waitClks(4);
        checkOutput("overrun deliveries", rise_cnt[0] - r0, 1);
        checkOutput("overrun rx_data", rx_data[0], 8'h11);
        checkOutput("overrun rx_valid", rx_valid[0], 1);
        checkOutput("overrun flag", overrun[0], 1);
        pulseReady();
        pulseClr();
        checkOutput("overrun cleared", overrun[0], 0);

        // Same pair, consuming exactly on the second byte's load cycle.
        sendFrame(0, 8'h11, 0, 1);
        lat1   = rise_cyc[0] - frame_start;
        target = cyc + lat1 - 1;
        fork
            sendFrame(0, 8'h22, 0, 1);
            begin
                while (cyc < target) waitClks(1);
                rx_ready = 1'b1;
                waitClks(1);
                rx_ready = 1'b0;
            end
        join
        waitClks(4);
        checkOutput("sameclk rx_data", rx_data[0], 8'h22);
        checkOutput("sameclk rx_valid", rx_valid[0], 1);
        checkOutput("sameclk overrun", overrun[0], 0);
        pulseReady();

        for (int i = 0; i < 16; i++) begin
            int   ch;
            logic [7:0] b;
            bit   flip, stop;
            ch   = $urandom_range(0, 2);
            b    = 8'($urandom_range(0, 255));
            flip = (ch != 0) && ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            v    = expectFrame(ch, b, flip, stop);
            applyStimulus(v, $sformatf("rand%0d", i));
        end

        // Reset in the middle of a data byte, with a byte already held.
        sendFrame(0, 8'h5A, 0, 1);
        waitClks(4);
        checkOutput("pre-reset rx_valid", rx_valid[0], 1);
        driveBit(0, 1'b0, BIT_CLKS);
        driveBit(0, 1'b0, BIT_CLKS);
        driveBit(0, 1'b1, BIT_CLKS);
        driveBit(0, 1'b1, 7);
        rst_n = 1'b0;
        waitClks(2);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("midreset ch%0d outputs", g),
                        {rx_data[g], rx_valid[g], frame_err[g], parity_err[g], overrun[g]}, 0);
        end
        line[0] = 1'b1;
        waitClks(2);
        rst_n = 1'b1;
        waitClks(20);
        r0 = rise_cnt[0];
        sendFrame(0, 8'h81, 0, 1);
        waitClks(4);
        checkOutput("postreset deliveries", rise_cnt[0] - r0, 1);
        checkOutput("postreset rx_data", rx_data[0], 8'h81);
        checkOutput("postreset flags", {frame_err[0], parity_err[0], overrun[0]}, 0);
        pulseReady();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
